// File: rtl/sync_stream_fifo.sv
// sync_stream_fifo: single-clock N-entry FIFO with valid/ready handshakes on
// both sides. The head word is shown ahead (first-word-fall-through). The FIFO
// also reports its occupancy and an almost-full flag.
//
// Build option: define FIFO_BYPASS_EN to add a zero-latency path while empty.
// In that build, a word offered on an empty FIFO appears on rd_* in the same
// cycle. If the consumer also takes it in that cycle, it is never stored.
// The default build (macro undefined) has no combinational path from wr_* to rd_*.
//
// Handshake semantics (both sides):
//   A write fires on wr_en & wr_ready. A read fires on rd_en & rd_valid.
//   wr_ready depends only on registered state and never on rd_en.
//   rd_valid/rd_data may depend on wr_* only in the bypass build.
//   rd_data reads as zero whenever rd_valid is low, including during reset.

module sync_stream_fifo #(
  parameter int WIDTH     = 42,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  // Pointer width; DEPTH need not be a power of two, so pointers wrap explicitly.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  // Storage is deliberately not reset; rd_data is masked until valid.
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_pass;      // word goes straight through (bypass only)
  logic             w_push;      // word is written into storage
  logic             w_pop;       // head word leaves storage
  logic             w_rd_valid;
  logic [WIDTH-1:0] w_head;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // Head selection, pass-through detection and push/pop decode.
  always_comb begin
    w_rd_valid = !w_empty;
    w_head     = r_mem[r_rd_ptr];
    w_pass     = 1'b0;
`ifdef FIFO_BYPASS_EN
    // Gated with rst_n so the outputs hold their reset values while reset is asserted.
    if (w_empty && wr_en && rst_n) begin
      w_rd_valid = 1'b1;
      w_head     = wr_data;
      w_pass     = rd_en;
    end
`endif
    // A full FIFO ignores writes. An empty FIFO never pops storage.
    w_push = wr_en && !w_full && !w_pass;
    w_pop  = rd_en && !w_empty;
  end

  // Write pointer advances with an explicit wrap at DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
    end
  end

  // Read pointer advances with the same wrap rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
    end
  end

  // Occupancy: write-only adds one, read-only removes one, and both together hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  assign wr_ready    = !w_full;
  assign rd_valid    = w_rd_valid;
  assign rd_data     = w_rd_valid ? w_head : '0;
  assign count       = r_count;
  assign almost_full = (r_count >= AF_C);

endmodule
